// File: rtl/axi_mem_responder.sv
// AXI4 responder on a single-port 64-bit SRAM that mimics the DDR controller's init status.
// Optional AXI_MEM_CLEAR_EN zeroes the RAM during INIT; without it INIT lasts one cycle.
module axi_mem_responder #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic                o_init_done,
    output logic                o_init_error
);
    localparam int WORD_AW = ADDR_WIDTH - 3;
    localparam int DEPTH   = 1 << WORD_AW;

    typedef enum logic [2:0] {INIT, IDLE, WDATA, WRESP, RDATA} state_e;

    state_e              state_q, state_d;
    logic [WORD_AW-1:0]  addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                fixed_q, fixed_d;
    logic                last_rd_q, last_rd_d;
    logic                init_done_q, init_done_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
    logic                rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [63:0]         rdata_q;
`ifdef AXI_MEM_CLEAR_EN
    logic [WORD_AW:0]    clr_q, clr_d;
`endif

    logic               grant_w, aw_hs, ar_hs, w_hs, r_hs;
    logic               ram_we, ram_re;
    logic [WORD_AW-1:0] ram_addr;
    logic [63:0]        ram_wdata;
    logic [7:0]         ram_be;
    logic [63:0]        mem [DEPTH];

    // Address bits outside the decoded window and WLAST are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{i_awaddr[31:ADDR_WIDTH], i_awaddr[2:0],
                           i_araddr[31:ADDR_WIDTH], i_araddr[2:0], i_wlast};

    // With both or neither requester valid, the channel not served last is offered.
    assign grant_w   = (i_awvalid != i_arvalid) ? i_awvalid : last_rd_q;
    assign o_awready = (state_q == IDLE) && grant_w;
    assign o_arready = (state_q == IDLE) && !grant_w;
    assign o_wready  = (state_q == WDATA);
    assign o_bvalid  = (state_q == WRESP);

    assign aw_hs = o_awready && i_awvalid;
    assign ar_hs = o_arready && i_arvalid;
    assign w_hs  = o_wready && i_wvalid;
    assign r_hs  = rvalid_q && i_rready;

    // A new word is fetched before the first beat and on every non-final R handshake.
    assign ram_re = (state_q == RDATA) && (!rvalid_q || (i_rready && !rlast_q));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        fixed_d     = fixed_q;
        last_rd_d   = last_rd_q;
        init_done_d = init_done_q;
        bid_d       = bid_q;
        rid_d       = rid_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        ram_we      = 1'b0;
        ram_addr    = addr_q;
        ram_wdata   = i_wdata;
        ram_be      = i_wstrb;
`ifdef AXI_MEM_CLEAR_EN
        clr_d       = clr_q;
`endif
        case (state_q)
            INIT: begin
`ifdef AXI_MEM_CLEAR_EN
                ram_we    = !clr_q[WORD_AW];
                ram_addr  = clr_q[WORD_AW-1:0];
                ram_wdata = '0;
                ram_be    = '1;
                if (clr_q[WORD_AW]) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    clr_d = clr_q + (WORD_AW+1)'(1);
                end
`else
                state_d     = IDLE;
                init_done_d = 1'b1;
`endif
            end
            IDLE: begin
                if (aw_hs) begin
                    state_d   = WDATA;
                    addr_d    = i_awaddr[ADDR_WIDTH-1:3];
                    cnt_d     = i_awlen;
                    fixed_d   = (i_awburst == 2'b00);
                    bid_d     = i_awid;
                    last_rd_d = 1'b0;
                end else if (ar_hs) begin
                    state_d   = RDATA;
                    addr_d    = i_araddr[ADDR_WIDTH-1:3];
                    cnt_d     = i_arlen;
                    fixed_d   = (i_arburst == 2'b00);
                    rid_d     = i_arid;
                    last_rd_d = 1'b1;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q - 8'd1;
                    if (!fixed_q) addr_d = addr_q + WORD_AW'(1);
                    if (cnt_q == 8'd0) state_d = WRESP;
                end
            end
            WRESP: begin
                if (i_bready) state_d = IDLE;
            end
            RDATA: begin
                if (ram_re) begin
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == 8'd0);
                    cnt_d    = cnt_q - 8'd1;
                    if (!fixed_q) addr_d = addr_q + WORD_AW'(1);
                end else if (r_hs) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            addr_q      <= '0;
            cnt_q       <= '0;
            fixed_q     <= 1'b0;
            last_rd_q   <= 1'b0;
            init_done_q <= 1'b0;
            bid_q       <= '0;
            rid_q       <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
`ifdef AXI_MEM_CLEAR_EN
            clr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            fixed_q     <= fixed_d;
            last_rd_q   <= last_rd_d;
            init_done_q <= init_done_d;
            bid_q       <= bid_d;
            rid_q       <= rid_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
`ifdef AXI_MEM_CLEAR_EN
            clr_q       <= clr_d;
`endif
        end
    end

    // NOTE: the array itself has no reset so it maps onto block RAM; only its output register resets.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            for (int b = 0; b < 8; b++) begin
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (ram_re) begin
            rdata_q <= mem[ram_addr];
        end
    end

    assign o_bid        = bid_q;
    assign o_bresp      = 2'b00;
    assign o_rid        = rid_q;
    assign o_rdata      = rdata_q;
    assign o_rresp      = 2'b00;
    assign o_rlast      = rlast_q;
    assign o_rvalid     = rvalid_q;
    assign o_init_done  = init_done_q;
    assign o_init_error = 1'b0;
endmodule
